// File: rtl/mem_byte_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : mem_byte_initiator
//  Purpose  : Bus-master front end that splits a CPU byte/half/word request
//             into little-endian byte beats on a byte-wide memory interface,
//             assembles read data and reports misalignment and timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module mem_byte_initiator #(
   parameter int addressWidth = 32,
   parameter int dataWidth    = 8,
   parameter int TIMEOUT      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // CPU side
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [1:0]              cpu_size,
   input  logic [addressWidth-1:0] cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [31:0]             cpu_rdata,
   // Memory side
   output logic                    readmem,
   output logic                    writemem,
   output logic [addressWidth-1:0] addressBus,
   output logic [dataWidth-1:0]    dataBusOut,
   input  logic [dataWidth-1:0]    dataBusIn,
   input  logic                    memDataReady
);

   // FSM encoding
   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCESS = 2'd1;
   localparam logic [1:0] c_DONE   = 2'd2;

   // Wait counter sized to hold TIMEOUT-1; a TIMEOUT of 0 disables the abort
   localparam int                WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] c_WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   logic [1:0]              r_state;
   logic                    r_we;
   logic [1:0]              r_lastBeat;
   logic [addressWidth-1:0] r_addr;
   logic [31:0]             r_wdata;
   logic [1:0]              r_beat;
   logic [WAIT_W-1:0]       r_waitCnt;
   logic [31:0]             r_rdAccum;
   logic [31:0]             r_rdata;
   logic                    r_err;

   logic                    w_strobe;
   logic                    w_beatDone;
   logic                    w_isLastBeat;
   logic                    w_timeout;
   logic                    w_reqBad;
   logic [1:0]              w_reqLastBeat;
   logic [31:0]             w_rdAccumNext;

   // Decode request size into last beat index and detect illegal requests
   always_comb begin
      w_reqLastBeat = 2'd0;
      w_reqBad      = 1'b0;
      case (cpu_size)
         2'b00: w_reqLastBeat = 2'd0;
         2'b01: begin
            w_reqLastBeat = 2'd1;
            w_reqBad      = cpu_addr[0];
         end
         2'b10: begin
            w_reqLastBeat = 2'd3;
            w_reqBad      = (cpu_addr[1:0] != 2'b00);
         end
         default: w_reqBad = 1'b1;
      endcase
   end

   assign w_strobe     = (r_state == c_ACCESS);
   assign w_beatDone   = w_strobe & memDataReady;
   assign w_isLastBeat = (r_beat == r_lastBeat);
   assign w_timeout    = w_strobe & ~memDataReady & (TIMEOUT != 0) &
                         (r_waitCnt == c_WAIT_LAST);

   // Merge the incoming read byte into its lane of the accumulator
   always_comb begin
      w_rdAccumNext = r_rdAccum;
      for (int b = 0; b < 4; b++) begin
         if (r_beat == 2'(b)) begin
            w_rdAccumNext[b*dataWidth +: dataWidth] = dataBusIn;
         end
      end
   end

   // Main transaction FSM: accept, step through beats, report completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_we       <= 1'b0;
         r_lastBeat <= 2'd0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_beat     <= 2'd0;
         r_waitCnt  <= '0;
         r_rdAccum  <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_err <= 1'b0;
               if (cpu_req) begin
                  r_we       <= cpu_we;
                  r_addr     <= cpu_addr;
                  r_wdata    <= cpu_wdata;
                  r_lastBeat <= w_reqLastBeat;
                  r_beat     <= 2'd0;
                  r_waitCnt  <= '0;
                  r_rdAccum  <= '0;
                  if (w_reqBad) begin
                     r_err   <= 1'b1;
                     r_state <= c_DONE;
                  end else begin
                     r_state <= c_ACCESS;
                  end
               end
            end
            c_ACCESS: begin
               if (w_beatDone) begin
                  r_waitCnt <= '0;
                  if (!r_we) begin
                     r_rdAccum <= w_rdAccumNext;
                  end
                  if (w_isLastBeat) begin
                     r_err   <= 1'b0;
                     r_state <= c_DONE;
                  end else begin
                     r_beat <= r_beat + 2'd1;
                  end
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= c_DONE;
               end else begin
                  r_waitCnt <= r_waitCnt + WAIT_W'(1);
               end
            end
            c_DONE: begin
               r_beat  <= 2'd0;
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Publish load data only when the final beat of a load lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (w_beatDone && w_isLastBeat && !r_we) begin
         r_rdata <= w_rdAccumNext;
      end
   end

   // Bus drive derives from state so an async reset drops strobes at once
   assign readmem    = w_strobe & ~r_we;
   assign writemem   = w_strobe & r_we;
   assign addressBus = w_strobe ? (r_addr + addressWidth'(r_beat)) : '0;
   assign dataBusOut = (w_strobe && r_we) ? r_wdata[int'(r_beat)*dataWidth +: dataWidth] : '0;

   assign busy      = (r_state != c_IDLE);
   assign done      = (r_state == c_DONE);
   assign err       = (r_state == c_DONE) & r_err;
   assign cpu_rdata = r_rdata;

endmodule
`default_nettype wire
